// File: rtl/snake_pkg.sv
// Shared types for the snake game core: movement direction and top-level game state.
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DEAD = 1'b1
    } state_t;

    function automatic dir_t opposite(input dir_t d);
        case (d)
            DIR_UP:   opposite = DIR_DOWN;
            DIR_DOWN: opposite = DIR_UP;
            DIR_LEFT: opposite = DIR_RIGHT;
            default:  opposite = DIR_LEFT;
        endcase
    endfunction

endpackage

// File: rtl/snake_next_head.sv
// Combinational next-head calculator: one cell in dir, wrapping or flagging out-of-bounds.
module snake_next_head
    import snake_pkg::*;
#(
    parameter int GRID_W = 40,
    parameter int GRID_H = 30,
    localparam int XW = $clog2(GRID_W),
    localparam int YW = $clog2(GRID_H)
) (
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    input  dir_t          dir,
    input  logic          walls_on,
    output logic [XW-1:0] nx,
    output logic [YW-1:0] ny,
    output logic          out_of_bounds
);

    // Up decreases y (screen coordinates); edge cells either wrap or report a wall hit.
    always_comb begin
        nx            = x;
        ny            = y;
        out_of_bounds = 1'b0;
        case (dir)
            DIR_UP: begin
                if (y == '0) begin
                    out_of_bounds = walls_on;
                    ny            = YW'(GRID_H - 1);
                end else ny = y - YW'(1);
            end
            DIR_DOWN: begin
                if (y == YW'(GRID_H - 1)) begin
                    out_of_bounds = walls_on;
                    ny            = '0;
                end else ny = y + YW'(1);
            end
            DIR_LEFT: begin
                if (x == '0) begin
                    out_of_bounds = walls_on;
                    nx            = XW'(GRID_W - 1);
                end else nx = x - XW'(1);
            end
            default: begin
                if (x == XW'(GRID_W - 1)) begin
                    out_of_bounds = walls_on;
                    nx            = '0;
                end else nx = x + XW'(1);
            end
        endcase
    end

endmodule

// File: rtl/snake_body_engine.sv
// Snake game core: direction latch, body shift register, growth, collision and query port.
module snake_body_engine
    import snake_pkg::*;
#(
    parameter int GRID_W   = 40,
    parameter int GRID_H   = 30,
    parameter int MAX_LEN  = 32,
    parameter int INIT_LEN = 3,
    localparam int XW = $clog2(GRID_W),
    localparam int YW = $clog2(GRID_H),
    localparam int LW = $clog2(MAX_LEN + 1)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          step,
    input  logic          dir_up,
    input  logic          dir_down,
    input  logic          dir_left,
    input  logic          dir_right,
    input  logic          walls_on,
    input  logic          food_valid,
    input  logic [XW-1:0] food_x,
    input  logic [YW-1:0] food_y,
    input  logic [XW-1:0] query_x,
    input  logic [YW-1:0] query_y,
    output logic          query_hit,
    output logic          query_head,
    output logic [XW-1:0] head_x,
    output logic [YW-1:0] head_y,
    output logic [LW-1:0] length,
    output logic          ate,
    output logic          game_over
);

    logic [MAX_LEN-1:0][XW-1:0] seg_x;
    logic [MAX_LEN-1:0][YW-1:0] seg_y;
    logic [MAX_LEN-1:0]         self_vec;
    logic [MAX_LEN-1:0]         query_vec;

    state_t        state, state_nxt;
    dir_t          dir, pending, req_dir, eff_dir;
    logic          req_ok, move, grow, can_grow, oob, die;
    logic [XW-1:0] nx;
    logic [YW-1:0] ny;
    logic [LW-1:0] limit;

    always_comb begin
        req_dir = DIR_RIGHT;
        if (dir_up)        req_dir = DIR_UP;
        else if (dir_down) req_dir = DIR_DOWN;
        else if (dir_left) req_dir = DIR_LEFT;
    end

    // A same-cycle request steers the step it arrives with.
    assign req_ok  = ($countones({dir_up, dir_down, dir_left, dir_right}) == 1)
                     && (req_dir != opposite(dir));
    assign eff_dir = req_ok ? req_dir : pending;

    snake_next_head #(.GRID_W(GRID_W), .GRID_H(GRID_H)) u_next_head (
        .x            (seg_x[0]),
        .y            (seg_y[0]),
        .dir          (eff_dir),
        .walls_on     (walls_on),
        .nx           (nx),
        .ny           (ny),
        .out_of_bounds(oob)
    );

    assign move     = (state == ST_RUN) && step;
    assign grow     = food_valid && (nx == food_x) && (ny == food_y);
    assign can_grow = (length < LW'(MAX_LEN));
    // The tail cell vacates on a plain move, so it only counts when the body grows.
    assign limit    = (grow && can_grow) ? length : length - LW'(1);

    always_comb begin
        self_vec  = '0;
        query_vec = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            self_vec[i]  = (i < int'(limit)) && (seg_x[i] == nx) && (seg_y[i] == ny);
            query_vec[i] = (i < int'(length)) && (seg_x[i] == query_x) && (seg_y[i] == query_y);
        end
    end

    assign die = move && (oob || (|self_vec));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= ST_RUN;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (die) state_nxt = ST_DEAD;
    end

    always_comb begin
        game_over = (state == ST_DEAD);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= (i < INIT_LEN) ? XW'(GRID_W / 2 - i) : '0;
                seg_y[i] <= (i < INIT_LEN) ? YW'(GRID_H / 2) : '0;
            end
            dir        <= DIR_RIGHT;
            pending    <= DIR_RIGHT;
            length     <= LW'(INIT_LEN);
            ate        <= 1'b0;
            query_hit  <= 1'b0;
            query_head <= 1'b0;
        end else begin
            query_hit  <= |query_vec;
            query_head <= (seg_x[0] == query_x) && (seg_y[0] == query_y);
            ate        <= move && grow && !die;
            if (state == ST_RUN && req_ok) pending <= req_dir;
            if (move) dir <= eff_dir;
            if (move && !die) begin
                for (int i = MAX_LEN - 1; i > 0; i--) begin
                    seg_x[i] <= seg_x[i-1];
                    seg_y[i] <= seg_y[i-1];
                end
                seg_x[0] <= nx;
                seg_y[0] <= ny;
                if (grow && can_grow) length <= length + LW'(1);
            end
        end
    end

    assign head_x = seg_x[0];
    assign head_y = seg_y[0];

endmodule

// File: tb/tb_snake_body_engine.sv
// Bench for snake_body_engine: directed scenarios plus random play against a cell-list model.
module tb_snake_body_engine;

    localparam int W  = 40;
    localparam int H  = 30;
    localparam int ML = 32;
    localparam int IL = 3;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       step = 1'b0;
    logic       dir_up = 1'b0, dir_down = 1'b0, dir_left = 1'b0, dir_right = 1'b0;
    logic       walls_on = 1'b0;
    logic       food_valid = 1'b0;
    logic [5:0] food_x = '0, query_x = '0;
    logic [4:0] food_y = '0, query_y = '0;
    logic       query_hit, query_head, ate, game_over;
    logic [5:0] head_x;
    logic [4:0] head_y;
    logic [5:0] length;

    snake_body_engine #(.GRID_W(W), .GRID_H(H), .MAX_LEN(ML), .INIT_LEN(IL)) dut (
        .clock(clock), .reset_n(reset_n), .step(step),
        .dir_up(dir_up), .dir_down(dir_down), .dir_left(dir_left), .dir_right(dir_right),
        .walls_on(walls_on), .food_valid(food_valid), .food_x(food_x), .food_y(food_y),
        .query_x(query_x), .query_y(query_y), .query_hit(query_hit), .query_head(query_head),
        .head_x(head_x), .head_y(head_y), .length(length), .ate(ate), .game_over(game_over)
    );

    always #5 clock = ~clock;

    // Model: direction index 0..3 = up/down/left/right, body kept as a coordinate list.
    int dxt[4] = '{0, 0, -1, 1};
    int dyt[4] = '{-1, 1, 0, 0};
    int mx[ML], my[ML];
    int mlen, mdir, mpend;
    bit mdead, mate, mqhit, mqhead;
    int n_chk = 0, n_pass = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < ML; i++) begin
            mx[i] = (i < IL) ? W / 2 - i : 0;
            my[i] = H / 2;
        end
        mlen = IL; mdir = 3; mpend = 3;
        mdead = 0; mate = 0; mqhit = 0; mqhead = 0;
    endtask

    task automatic model_edge();
        int cnt, req, nx, ny, lim;
        bit grow, hit;
        mqhit = 0;
        for (int i = 0; i < mlen; i++)
            if (mx[i] == int'(query_x) && my[i] == int'(query_y)) mqhit = 1;
        mqhead = (mx[0] == int'(query_x)) && (my[0] == int'(query_y));
        mate = 0;
        if (mdead) return;
        cnt = int'(dir_up) + int'(dir_down) + int'(dir_left) + int'(dir_right);
        req = dir_up ? 0 : dir_down ? 1 : dir_left ? 2 : 3;
        if (cnt == 1 && !(dxt[req] == -dxt[mdir] && dyt[req] == -dyt[mdir])) mpend = req;
        if (!step) return;
        mdir = mpend;
        nx = mx[0] + dxt[mdir];
        ny = my[0] + dyt[mdir];
        if (walls_on && (nx < 0 || nx >= W || ny < 0 || ny >= H)) begin
            mdead = 1;
            return;
        end
        nx = (nx + W) % W;
        ny = (ny + H) % H;
        grow = food_valid && nx == int'(food_x) && ny == int'(food_y);
        lim = (grow && mlen < ML) ? mlen : mlen - 1;
        hit = 0;
        for (int i = 0; i < lim; i++) if (mx[i] == nx && my[i] == ny) hit = 1;
        if (hit) begin
            mdead = 1;
            return;
        end
        for (int i = ML - 1; i > 0; i--) begin
            mx[i] = mx[i-1];
            my[i] = my[i-1];
        end
        mx[0] = nx; my[0] = ny;
        if (grow && mlen < ML) mlen++;
        mate = grow;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clock);
        #1;
        check("head_x", int'(head_x), mx[0]);
        check("head_y", int'(head_y), my[0]);
        check("length", int'(length), mlen);
        check("game_over", int'(game_over), int'(mdead));
        check("ate", int'(ate), int'(mate));
        check("query_hit", int'(query_hit), int'(mqhit));
        check("query_head", int'(query_head), int'(mqhead));
    endtask

    task automatic clr_in();
        step = 0; dir_up = 0; dir_down = 0; dir_left = 0; dir_right = 0; food_valid = 0;
    endtask

    task automatic set_dir(input int d);
        dir_up = (d == 0); dir_down = (d == 1); dir_left = (d == 2); dir_right = (d == 3);
    endtask

    task automatic do_reset();
        clr_in();
        reset_n = 0;
        #2;
        check("rst_head_x", int'(head_x), W / 2);
        check("rst_head_y", int'(head_y), H / 2);
        check("rst_length", int'(length), IL);
        check("rst_game_over", int'(game_over), 0);
        check("rst_ate", int'(ate), 0);
        check("rst_query_hit", int'(query_hit), 0);
        check("rst_query_head", int'(query_head), 0);
        reset_n = 1;
        model_reset();
    endtask

    // One step, optional direction (-1 = none), optional food directly ahead of the new head.
    task automatic mv(input int d, input bit feed);
        int fd;
        clr_in();
        if (d >= 0) set_dir(d);
        step = 1;
        if (feed) begin
            fd = (d >= 0 && !(dxt[d] == -dxt[mdir] && dyt[d] == -dyt[mdir])) ? d : mpend;
            food_valid = 1;
            food_x = 6'((mx[0] + dxt[fd] + W) % W);
            food_y = 5'((my[0] + dyt[fd] + H) % H);
        end
        tick();
        clr_in();
    endtask

    initial begin
        @(posedge clock);
        #1;
        do_reset();
        query_x = 6'd20; query_y = 5'd15;
        mv(-1, 0);
        check("first_step_x", int'(head_x), 21);
        check("first_step_len", int'(length), 3);

        // Left against RIGHT is dropped; from DOWN, Up is dropped and Left is taken.
        mv(2, 0);
        check("left_ignored_x", int'(head_x), 22);
        mv(1, 0);
        clr_in(); set_dir(0); tick();
        clr_in(); set_dir(2); tick();
        mv(-1, 0);
        check("up_left_x", int'(head_x), 21);

        // Wrap versus wall at the right edge.
        do_reset();
        walls_on = 0;
        for (int i = 0; i < 19; i++) mv(-1, 0);
        mv(-1, 0);
        check("wrap_x", int'(head_x), 0);
        do_reset();
        walls_on = 1;
        for (int i = 0; i < 19; i++) mv(-1, 0);
        mv(-1, 0);
        check("wall_dead", int'(game_over), 1);
        check("wall_x", int'(head_x), 39);
        mv(0, 0);
        mv(1, 1);
        check("dead_frozen_x", int'(head_x), 39);
        check("dead_frozen_y", int'(head_y), 15);

        // Grow to capacity along a wrapping row, then one saturating meal.
        do_reset();
        walls_on = 0;
        mv(-1, 1);
        check("grow_ate", int'(ate), 1);
        check("grow_len", int'(length), 4);
        mv(-1, 0);
        check("ate_one_cycle", int'(ate), 0);
        for (int i = 0; i < ML - 4; i++) mv(-1, 1);
        check("max_len", int'(length), ML);
        mv(-1, 1);
        check("sat_ate", int'(ate), 1);
        check("sat_len", int'(length), ML);

        // Mid-game reset restores everything.
        do_reset();

        // Length 5 curl into the body dies; length 4 square chases its tail and lives.
        mv(-1, 1); mv(-1, 1);
        mv(0, 0); mv(2, 0); mv(1, 0);
        check("self_hit", int'(game_over), 1);
        do_reset();
        mv(-1, 1);
        mv(0, 0); mv(2, 0); mv(1, 0);
        check("tail_chase_alive", int'(game_over), 0);

        // Query every body cell, then an off-body cell.
        for (int i = 0; i < mlen; i++) begin
            query_x = 6'(mx[i]); query_y = 5'(my[i]);
            tick();
            check("query_body", int'(query_hit), 1);
        end
        query_x = 6'd5; query_y = 5'd5;
        tick();
        check("query_off", int'(query_hit), 0);

        // Random play.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            clr_in();
            if ($urandom_range(3) == 0) begin
                if ($urandom_range(7) == 0) begin
                    dir_up = 1'($urandom); dir_down = 1'($urandom);
                    dir_left = 1'($urandom); dir_right = 1'($urandom);
                end else set_dir(int'($urandom_range(3)));
            end
            step = 1'($urandom);
            walls_on = ($urandom_range(15) == 0) ? ~walls_on : walls_on;
            food_valid = 1'($urandom);
            if ($urandom_range(1) == 0) begin
                food_x = 6'((mx[0] + dxt[mpend] + W) % W);
                food_y = 5'((my[0] + dyt[mpend] + H) % H);
            end else begin
                food_x = 6'($urandom_range(W - 1));
                food_y = 5'($urandom_range(H - 1));
            end
            if ($urandom_range(3) != 0) begin
                int k = int'($urandom_range(mlen - 1));
                query_x = 6'(mx[k]); query_y = 5'(my[k]);
            end else begin
                query_x = 6'($urandom_range(W - 1));
                query_y = 5'($urandom_range(H - 1));
            end
            tick();
            if (mdead && $urandom_range(7) == 0) do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
